if_id_buffer: RTL and testbench

//   Fetch-to-decode elastic buffer for the RV32I pipeline: DEPTH-entry FIFO holding instr, PC and branch-prediction info.
//   Pre-decodes the immediate-format selector and the instr[31:7] field consumed by the immediate extender in ID.

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/imm_sel_decode.sv | 40 ++++
 rtl/if_id_buffer.sv | 142 ++++++++++++++
 tb/tb_if_id_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared RV32I encodings for the fetch/decode front end.
//   Opcode constants, immediate-format selector codes, the canonical NOP
//   and the IF/ID buffer entry layout.
package rv32i_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] FENCE  = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   // Immediate-format selector consumed by the ID immediate extender
   localparam logic [2:0] IMM_I  = 3'b000;
   localparam logic [2:0] IMM_S  = 3'b001;
   localparam logic [2:0] IMM_B  = 3'b010;
   localparam logic [2:0] IMM_SH = 3'b011;
   localparam logic [2:0] IMM_J  = 3'b100;
   localparam logic [2:0] IMM_U  = 3'b101;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // One buffered fetch packet, pre-decode results stored alongside
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic [2:0]  imm_sel;
      logic        illegal;
   } ifid_entry_t;

endpackage

// File: rtl/imm_sel_decode.sv
// imm_sel_decode -- combinational pre-decode of the immediate format.
//   instr   in  32  fetched instruction
//   imm_sel out 3   immediate format selector (IMM_* codes)
//   illegal out 1   opcode not part of the supported RV32I subset
// Sits on the push path of the IF/ID buffer so ID sees the result
// straight out of a flop.
module imm_sel_decode
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  imm_sel,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign unused_bits = ^{instr[31:15], instr[11:7]};

   always_comb begin
      imm_sel = IMM_I;
      illegal = 1'b0;
      case (opcode)
         // slli/srli/srai carry a 5-bit shamt instead of a 12-bit immediate
         OP_IMM: if (funct3 == 3'b001 || funct3 == 3'b101) imm_sel = IMM_SH;
         LOAD, JALR:          imm_sel = IMM_I;
         STORE:               imm_sel = IMM_S;
         BRANCH:              imm_sel = IMM_B;
         JAL:                 imm_sel = IMM_J;
         LUI, AUIPC:          imm_sel = IMM_U;
         // no immediate used, but legal
         OP, FENCE, SYSTEM:   imm_sel = IMM_I;
         default:             illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer -- fetch-to-decode elastic buffer for the RV32I pipeline.
//   DEPTH-entry FIFO of {instr, pc, prediction} plus pre-decoded immediate
//   selector / illegal flag. Latency 1 (no bypass), mispredict flush.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_valid/o_ready                   fetch handshake (o_ready = not full)
//   i_instr,i_pc,i_pred_taken,i_pred_target   fetch packet
//   i_stall                           decode cannot consume this cycle
//   i_flush                           discard all entries (wins over push)
//   o_valid,o_instr,o_pc,o_pred_taken,o_pred_target  head entry
//   o_imm_sel,o_imm_field,o_illegal   pre-decode of head entry
// Optional (macro IF_ID_PERF_CNT_EN):
//   o_stall_cnt  cycles with head valid and decode stalled
//   o_flush_cnt  flushes that discarded at least one entry
module if_id_buffer
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_pred_taken,
   input  logic [XLEN-1:0] i_pred_target,
   input  logic            i_stall,
   input  logic            i_flush,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_target,
   output logic [2:0]      o_imm_sel,
   output logic [24:0]     o_imm_field,
   output logic            o_illegal
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]     o_stall_cnt,
   output logic [31:0]     o_flush_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push;
   logic          pop;
   logic [2:0]    dec_sel;
   logic          dec_illegal;
   ifid_entry_t   wr_entry;
   ifid_entry_t   head;
   ifid_entry_t   mem [DEPTH];

   // Handshake only looks at registered count, keeping i_stall/i_valid
   // off the o_ready/o_valid timing paths.
   assign o_ready = (count != FULL_CNT);
   assign o_valid = (count != '0);
   assign push    = i_valid & o_ready & ~i_flush;
   assign pop     = o_valid & ~i_stall & ~i_flush;

   imm_sel_decode u_dec (
      .instr   (i_instr),
      .imm_sel (dec_sel),
      .illegal (dec_illegal)
   );

   assign wr_entry = '{instr:       i_instr,
                       pc:          i_pc,
                       pred_taken:  i_pred_taken,
                       pred_target: i_pred_target,
                       imm_sel:     dec_sel,
                       illegal:     dec_illegal};

   // Pointers are AW bits wide and DEPTH is a power of two, so the
   // natural rollover gives the modulo-DEPTH wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (i_flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: every read is masked by o_valid.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign head = mem[rd_ptr];

   // Empty buffer presents a NOP so ID can decode unconditionally.
   always_comb begin
      o_instr       = NOP_INSTR;
      o_pc          = '0;
      o_pred_taken  = 1'b0;
      o_pred_target = '0;
      o_imm_sel     = IMM_I;
      o_illegal     = 1'b0;
      if (o_valid) begin
         o_instr       = head.instr;
         o_pc          = head.pc;
         o_pred_taken  = head.pred_taken;
         o_pred_target = head.pred_target;
         o_imm_sel     = head.imm_sel;
         o_illegal     = head.illegal;
      end
   end

   assign o_imm_field = o_instr[31:7];

`ifdef IF_ID_PERF_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_valid & i_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
         if (i_flush & o_valid) o_flush_cnt <= o_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer -- directed + randomized bench for if_id_buffer.
// Reference model is a queue of fetch packets; pre-decode expectations
// come from an opcode table.
module tb_if_id_buffer;

   localparam int DEPTH = 2;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_instr = '0;
   logic [31:0] i_pc = '0;
   logic        i_pred_taken = 1'b0;
   logic [31:0] i_pred_target = '0;
   logic        i_stall = 1'b0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic [2:0]  o_imm_sel;
   logic [24:0] o_imm_field;
   logic        o_illegal;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] o_stall_cnt;
   logic [31:0] o_flush_cnt;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;
`endif

   always #5 i_clk = ~i_clk;

   if_id_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_instr(i_instr), .i_pc(i_pc), .i_pred_taken(i_pred_taken),
      .i_pred_target(i_pred_target), .i_stall(i_stall), .i_flush(i_flush),
      .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
      .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
      .o_imm_sel(o_imm_sel), .o_imm_field(o_imm_field), .o_illegal(o_illegal)
`ifdef IF_ID_PERF_CNT_EN
      , .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tgt;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   acc;
   logic [31:0] fpc;

   localparam logic [6:0] OPS [11] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                                      7'h37, 7'h17, 7'h33, 7'h0F, 7'h73};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // {illegal, sel} from the opcode/funct3 table
   function automatic logic [3:0] ref_dec(input logic [31:0] ins);
      logic [2:0] f3;
      f3 = ins[14:12];
      case (ins[6:0])
         7'h13:                             return (f3 == 3'd1 || f3 == 3'd5) ? 4'h3 : 4'h0;
         7'h03, 7'h67, 7'h33, 7'h0F, 7'h73: return 4'h0;
         7'h23:                             return 4'h1;
         7'h63:                             return 4'h2;
         7'h6F:                             return 4'h4;
         7'h37, 7'h17:                      return 4'h5;
         default:                           return 4'h8;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 12);
      if (k < 11) r[6:0] = OPS[k];
      return r;
   endfunction

   task automatic check_outputs();
      ent_t e;
      logic [3:0] d;
      if (q.size() == 0) e = '{instr: 32'h13, pc: 32'h0, tk: 1'b0, tgt: 32'h0};
      else               e = q[0];
      d = ref_dec(e.instr);
      chk("valid",  64'(o_valid), 64'(q.size() != 0));
      chk("ready",  64'(o_ready), 64'(q.size() != DEPTH));
      chk("instr",  64'(o_instr), 64'(e.instr));
      chk("pc",     64'(o_pc), 64'(e.pc));
      chk("taken",  64'(o_pred_taken), 64'(e.tk));
      chk("target", 64'(o_pred_target), 64'(e.tgt));
      chk("sel",    64'(o_imm_sel), 64'(d[2:0]));
      chk("ill",    64'(o_illegal), 64'(d[3]));
      chk("field",  64'(o_imm_field), 64'(e.instr >> 7));
`ifdef IF_ID_PERF_CNT_EN
      chk("stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(o_flush_cnt), 64'(m_flush));
`endif
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic stall, input logic flush);
      i_valid       = v;
      i_instr       = ins;
      i_pc          = pc;
      i_pred_taken  = ins[3];
      i_pred_target = pc ^ 32'h0000_1000;
      i_stall       = stall;
      i_flush       = flush;
   endtask

   // Check current outputs, advance the model by one clock, step the DUT.
   task automatic step(output bit accepted);
      bit do_pop;
      check_outputs();
      accepted = i_valid && (q.size() != DEPTH) && !i_flush;
      do_pop   = (q.size() != 0) && !i_stall && !i_flush;
`ifdef IF_ID_PERF_CNT_EN
      if (q.size() != 0 && i_stall) m_stall++;
      if (q.size() != 0 && i_flush) m_flush++;
`endif
      if (i_flush) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (accepted) q.push_back('{instr: i_instr, pc: i_pc, tk: i_pred_taken, tgt: i_pred_target});
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_flush();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step(acc);
   endtask

   initial begin
      logic [31:0] t4_ins [5];
      logic [2:0]  t4_sel [5];
      int          npop;
      t4_ins = '{32'h00A1_2023, 32'h0000_0463, 32'h0080_006F, 32'h1234_50B7, 32'h0031_1093};
      t4_sel = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      check_outputs();
      i_rst_n = 1'b1;

      // T1: addi
      drive(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
      step(acc);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("t1_valid", 64'(o_valid), 64'd1);
      chk("t1_sel",   64'(o_imm_sel), 64'd0);
      chk("t1_field", 64'(o_imm_field), 64'h00A001);
      chk("t1_ill",   64'(o_illegal), 64'd0);
      step(acc);
      idle_flush();

      // T2: stall, fill, fetch holds third, then drain in order
      fpc = 32'h0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h0000_0013 | (fpc << 20), fpc, 1'b1, 1'b0);
         step(acc);
         if (acc) fpc += 4;
      end
      chk("t2_ready", 64'(o_ready), 64'd0);
      chk("t2_held",  64'(fpc), 64'd8);
      npop = 0;
      for (int i = 0; i < 8; i++) begin
         drive(fpc < 12, 32'h0000_0013 | (fpc << 20), fpc, 1'b0, 1'b0);
         if (o_valid && npop < 3) begin
            chk("t2_order", 64'(o_pc), 64'(npop * 4));
            npop++;
         end
         step(acc);
         if (acc) fpc += 4;
      end
      chk("t2_npop", 64'(npop), 64'd3);

      // T3: flush while full with a concurrent push
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h0010_0093, 32'h40 + 32'(i * 4), 1'b1, 1'b0);
         step(acc);
      end
      chk("t3_full", 64'(o_ready), 64'd0);
      drive(1'b1, 32'h0020_0093, 32'h48, 1'b0, 1'b1);
      step(acc);
      chk("t3_valid", 64'(o_valid), 64'd0);
      chk("t3_ready", 64'(o_ready), 64'd1);
      chk("t3_instr", 64'(o_instr), 64'h13);

      // T4: immediate formats, one per cycle
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, t4_ins[i], 32'h100 + 32'(i * 4), 1'b0, 1'b0);
         step(acc);
         chk("t4_sel", 64'(o_imm_sel), 64'(t4_sel[i]));
      end
      // T5: illegal opcode
      drive(1'b1, 32'hFFFF_FFFF, 32'h200, 1'b0, 1'b0);
      step(acc);
      chk("t5_ill", 64'(o_illegal), 64'd1);
      chk("t5_sel", 64'(o_imm_sel), 64'd0);
      idle_flush();

      // T6: streaming push+pop
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, rand_instr(), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
         step(acc);
         chk("t6_valid", 64'(o_valid), 64'd1);
         chk("t6_ready", 64'(o_ready), 64'd1);
         chk("t6_pc",    64'(o_pc), 64'(32'h300 + 32'(i * 4)));
      end

      // Asynchronous reset mid-operation
      drive(1'b1, 32'h0000_0013, 32'h400, 1'b1, 1'b0);
      step(acc);
      i_rst_n = 1'b0;
      #1;
      q.delete();
`ifdef IF_ID_PERF_CNT_EN
      m_stall = '0;
      m_flush = '0;
`endif
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_instr", 64'(o_instr), 64'h13);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;

      // Randomized traffic; fetch holds its packet until accepted
      fpc = 32'h1000;
      i_instr = rand_instr();
      for (int i = 0; i < 500; i++) begin
         logic [31:0] ins;
         logic        flush;
         ins   = acc ? rand_instr() : i_instr;
         flush = ($urandom_range(0, 19) == 0);
         drive($urandom_range(0, 9) < 7, ins, fpc, $urandom_range(0, 9) < 3, flush);
         step(acc);
         if (flush) begin
            fpc = $urandom & 32'hFFFF_FFFC;
            acc = 1'b1;
         end else if (acc) fpc += 4;
      end
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
